// File: rtl/udma_eth_frame_pkg.sv
// Shared types and constants for the uDMA ethernet-frame TX path.
package udma_eth_frame_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, PAD, FCS, DONE} state_t;

  localparam int ETH_MIN_FRAME = 60;
  localparam int ETH_MAX_FRAME = 1514;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  // Reflected CRC-32 update over one byte, LSB first.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] poly_r;
    logic [31:0] c;
    for (int i = 0; i < 32; i++) poly_r[i] = CRC32_POLY[31-i];
    c = crc ^ {24'h0, data};
    for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/udma_eth_frame_tx_crc.sv
// Byte-wide CRC-32 engine: combinational next value, registered result.
module eth_crc32
  import udma_eth_frame_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i)
      crc_d = CRC32_INIT;
    else if (en_i)
      crc_d = crc32_next(crc_q, data_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      crc_q <= CRC32_INIT;
    else
      crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/udma_eth_frame_tx.sv
// uDMA word stream to MAC byte stream framer with sof/eof marking and minimum-length padding.
// Optional FCS append is built when ETH_FCS_EN is defined.
module udma_eth_frame_tx
  import udma_eth_frame_pkg::*;
#(
  parameter int MIN_FRAME = ETH_MIN_FRAME,
  parameter int MAX_FRAME = ETH_MAX_FRAME,
  parameter int LEN_W     = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             frame_start_i,
  input  logic [LEN_W-1:0] frame_len_i,
  input  logic [31:0]      data_tx_i,
  input  logic             data_tx_valid_i,
  output logic             data_tx_ready_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  output logic             tx_sof_o,
  output logic             tx_eof_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int               CNT_W   = LEN_W + 1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAME);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FRAME);
`ifdef ETH_FCS_EN
  localparam state_t TAIL    = FCS;
  localparam logic   HAS_FCS = 1'b1;
`else
  localparam state_t TAIL    = DONE;
  localparam logic   HAS_FCS = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      word_q;
  logic [CNT_W-1:0] len_in;
  logic             start_ok;
  logic             word_ld;
  logic             last_payload;
  logic             short_frame;

  assign start_ok     = frame_start_i && (frame_len_i != '0);
  assign len_in       = ({1'b0, frame_len_i} > MAX_CNT) ? MAX_CNT : {1'b0, frame_len_i};
  assign last_payload = (cnt_q == len_q - ONE);
  assign short_frame  = (len_q < MIN_CNT);
  assign word_ld      = data_tx_ready_o && data_tx_valid_i;
  assign busy_o       = (state_q != IDLE);

`ifdef ETH_FCS_EN
  logic [31:0] crc;
  logic [1:0]  fcs_q;
  logic [7:0]  fcs_byte;
  logic        crc_clr;
  logic        crc_en;

  assign crc_clr = (state_q == IDLE) && start_ok;
  assign crc_en  = tx_valid_o && tx_ready_i && ((state_q == SHIFT) || (state_q == PAD));

  eth_crc32 u_crc (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .data_i (tx_data_o),
    .crc_o  (crc)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      fcs_q <= '0;
    else if (crc_clr)
      fcs_q <= '0;
    else if ((state_q == FCS) && tx_ready_i)
      fcs_q <= fcs_q + 2'd1;
  end

  // Register holds the reflected CRC; complement on the way out, LSB byte first.
  assign fcs_byte = ~crc[{fcs_q, 3'b000} +: 8];
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (word_ld)
      word_q <= data_tx_i;
  end

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    lane_d          = lane_q;
    data_tx_ready_o = 1'b0;
    tx_valid_o      = 1'b0;
    tx_data_o       = '0;
    tx_sof_o        = 1'b0;
    tx_eof_o        = 1'b0;
    done_o          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          len_d   = len_in;
          cnt_d   = '0;
          lane_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        data_tx_ready_o = 1'b1;
        if (data_tx_valid_i)
          state_d = SHIFT;
      end
      SHIFT: begin
        tx_valid_o = 1'b1;
        tx_data_o  = word_q[{lane_q, 3'b000} +: 8];
        tx_sof_o   = (cnt_q == '0);
        tx_eof_o   = last_payload && !short_frame && !HAS_FCS;
        if (tx_ready_i) begin
          cnt_d = cnt_q + ONE;
          // The last payload byte ends the word early; leftover lanes are dropped.
          if (last_payload) begin
            lane_d  = '0;
            state_d = short_frame ? PAD : TAIL;
          end else if (lane_q == 2'd3) begin
            lane_d  = '0;
            state_d = FETCH;
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
      end
      PAD: begin
        tx_valid_o = 1'b1;
        tx_eof_o   = (cnt_q == MIN_CNT - ONE) && !HAS_FCS;
        if (tx_ready_i) begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == MIN_CNT - ONE)
            state_d = TAIL;
        end
      end
`ifdef ETH_FCS_EN
      FCS: begin
        tx_valid_o = 1'b1;
        tx_data_o  = fcs_byte;
        tx_eof_o   = (fcs_q == 2'd3);
        if (tx_ready_i && (fcs_q == 2'd3))
          state_d = DONE;
      end
`endif
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_udma_eth_frame_tx.sv
// Scoreboard bench for udma_eth_frame_tx: word source, MAC sink with optional random backpressure.
module tb_udma_eth_frame_tx;

  localparam int MIN = 60;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        frame_start_i = 1'b0;
  logic [15:0] frame_len_i = '0;
  logic [31:0] data_tx_i = '0;
  logic        data_tx_valid_i = 1'b0;
  logic        data_tx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_sof_o;
  logic        tx_eof_o;
  logic        tx_ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;

  udma_eth_frame_tx dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .frame_start_i   (frame_start_i),
    .frame_len_i     (frame_len_i),
    .data_tx_i       (data_tx_i),
    .data_tx_valid_i (data_tx_valid_i),
    .data_tx_ready_o (data_tx_ready_o),
    .tx_data_o       (tx_data_o),
    .tx_valid_o      (tx_valid_o),
    .tx_sof_o        (tx_sof_o),
    .tx_eof_o        (tx_eof_o),
    .tx_ready_i      (tx_ready_i),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] wq[$];
  logic [7:0]  pl[$];
  logic [7:0]  rx_bytes[$];
  int          nchk = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          sof_cyc = 0;
  int          eof_cyc = 0;
  bit          rand_ready = 1'b0;
  bit          word_acc = 1'b0;
  bit          eof_acc_prev = 1'b0;
  bit          stall_prev = 1'b0;
  logic [9:0]  held = '0;

  function automatic logic [31:0] m_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Source and sink drivers, updated just after each rising edge.
  always @(posedge clk_i) begin
    #1;
    if (word_acc && wq.size() > 0) void'(wq.pop_front());
    data_tx_valid_i = (wq.size() > 0);
    data_tx_i       = (wq.size() > 0) ? wq[0] : 32'h0;
    tx_ready_i      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor on the falling edge: handshakes, scoreboard, stall hold, done timing.
  always @(negedge clk_i) begin
    exp_t e;
    cyc++;
    word_acc = data_tx_valid_i && data_tx_ready_o;
    if (stall_prev) begin
      nchk++;
      if (tx_valid_o !== 1'b1 || {tx_data_o, tx_sof_o, tx_eof_o} !== held) begin
        nerr++;
        $display("FAIL stall_hold: got valid=%b bus=%h, expected valid=1 bus=%h", tx_valid_o, {tx_data_o, tx_sof_o, tx_eof_o}, held);
      end
    end
    stall_prev = rstn_i && tx_valid_o && !tx_ready_i;
    held = {tx_data_o, tx_sof_o, tx_eof_o};
    if (eof_acc_prev || done_o) begin
      nchk++;
      if (done_o !== eof_acc_prev) begin
        nerr++;
        $display("FAIL done_pulse: got done=%b, expected %b", done_o, eof_acc_prev);
      end
    end
    eof_acc_prev = 1'b0;
    if (done_o) done_cnt++;
    if (tx_valid_o && tx_ready_i) begin
      rx_bytes.push_back(tx_data_o);
      if (tx_sof_o) sof_cyc = cyc;
      if (tx_eof_o) begin
        eof_cyc = cyc;
        eof_acc_prev = 1'b1;
      end
      nchk++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_byte: got data=%h sof=%b eof=%b, expected no byte", tx_data_o, tx_sof_o, tx_eof_o);
      end else begin
        e = exp_q.pop_front();
        if ({tx_data_o, tx_sof_o, tx_eof_o} !== {e.data, e.sof, e.eof}) begin
          nerr++;
          $display("FAIL byte: got data=%h sof=%b eof=%b, expected data=%h sof=%b eof=%b",
                   tx_data_o, tx_sof_o, tx_eof_o, e.data, e.sof, e.eof);
        end
      end
    end
  end

  // Queue words for the first n bytes of pl and the expected emitted frame.
  task automatic load_frame(input int n);
    logic [31:0] w;
    logic [7:0]  fr[$];
`ifdef ETH_FCS_EN
    logic [31:0] c;
`endif
    for (int i = 0; i < (n + 3) / 4; i++) begin
      w = 32'hEEEEEEEE;
      for (int b = 0; b < 4; b++)
        if (i * 4 + b < n) w[8*b +: 8] = pl[i*4+b];
      wq.push_back(w);
    end
    for (int i = 0; i < n; i++) fr.push_back(pl[i]);
    while (fr.size() < MIN) fr.push_back(8'h00);
`ifdef ETH_FCS_EN
    c = 32'hFFFFFFFF;
    foreach (fr[i]) c = m_crc(c, fr[i]);
    c = ~c;
    for (int b = 0; b < 4; b++) fr.push_back(c[8*b +: 8]);
`endif
    for (int i = 0; i < fr.size(); i++)
      exp_q.push_back('{data: fr[i], sof: (i == 0), eof: (i == fr.size() - 1)});
  endtask

  task automatic start(input int len);
    @(posedge clk_i); #2;
    frame_start_i = 1'b1;
    frame_len_i   = 16'(len);
    @(posedge clk_i); #2;
    frame_start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < limit && done_cnt == d0; i++) @(negedge clk_i);
    nchk++;
    if (done_cnt == d0) begin
      nerr++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", limit);
    end
    nchk++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL frame_bytes: got %0d bytes missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_i);
    nchk++;
    if ({data_tx_ready_o, tx_valid_o, tx_sof_o, tx_eof_o, busy_o, done_o, tx_data_o} !== 14'h0) begin
      nerr++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {data_tx_ready_o, tx_valid_o, tx_sof_o, tx_eof_o, busy_o, done_o, tx_data_o});
    end
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
  endtask

  task automatic test_short;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_frame(4);
    start(4);
    @(negedge clk_i);
    nchk++;
    if ({data_tx_ready_o, busy_o} !== 2'b11) begin
      nerr++;
      $display("FAIL start_latency: got ready=%b busy=%b, expected 1 1", data_tx_ready_o, busy_o);
    end
    @(negedge clk_i);
    nchk++;
    if ({tx_valid_o, tx_sof_o, tx_data_o} !== {2'b11, 8'h11}) begin
      nerr++;
      $display("FAIL first_byte_latency: got valid=%b sof=%b data=%h, expected 1 1 11", tx_valid_o, tx_sof_o, tx_data_o);
    end
    wait_done(200);
    nchk++;
    if (eof_cyc - sof_cyc != MIN - 1) begin
      nerr++;
      $display("FAIL no_bubble: got %0d cycles sof->eof, expected %0d", eof_cyc - sof_cyc, MIN - 1);
    end
    @(posedge clk_i); #1;
    nchk++;
    if (busy_o !== 1'b0) begin
      nerr++;
      $display("FAIL busy_after_done: got %b, expected 0", busy_o);
    end
  endtask

  task automatic test_full64;
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    load_frame(64);
    start(64);
    wait_done(400);
  endtask

  task automatic test_stall61;
    pl.delete();
    for (int i = 0; i < 61; i++) pl.push_back(8'($urandom_range(0, 255)));
    rand_ready = 1'b1;
    load_frame(61);
    start(61);
    wait_done(2000);
    rand_ready = 1'b0;
  endtask

  task automatic test_ignored_starts;
    bit seen;
    start(0);
    repeat (5) begin
      @(negedge clk_i);
      nchk++;
      if ({busy_o, tx_valid_o, data_tx_ready_o} !== 3'b000) begin
        nerr++;
        $display("FAIL len0_ignored: got busy=%b valid=%b ready=%b, expected 0 0 0", busy_o, tx_valid_o, data_tx_ready_o);
      end
    end
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(8'hA0 + 8'(i));
    load_frame(8);
    start(8);
    repeat (4) @(negedge clk_i);
    nchk++;
    if (busy_o !== 1'b1) begin
      nerr++;
      $display("FAIL busy_during_frame: got %b, expected 1", busy_o);
    end
    start(100);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
    end
    nchk++;
    if (!seen) begin
      nerr++;
      $display("FAIL done_timeout2: got no done, expected done");
    end
    frame_start_i = 1'b1;
    frame_len_i   = 16'd8;
    @(posedge clk_i); #2;
    frame_start_i = 1'b0;
    nchk++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL frame_len_kept: got %0d bytes missing, expected 0", exp_q.size());
    end
    repeat (3) begin
      @(negedge clk_i);
      nchk++;
      if ({busy_o, tx_valid_o, data_tx_ready_o} !== 3'b000) begin
        nerr++;
        $display("FAIL start_at_done_ignored: got busy=%b valid=%b ready=%b, expected 0 0 0", busy_o, tx_valid_o, data_tx_ready_o);
      end
    end
  endtask

  task automatic test_reset_mid_pad;
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'h50 + 8'(i));
    load_frame(10);
    start(10);
    for (int i = 0; i < 500 && exp_q.size() > 35; i++) @(negedge clk_i);
    nchk++;
    if (exp_q.size() > 35) begin
      nerr++;
      $display("FAIL reach_pad: got %0d bytes pending, expected <= 35", exp_q.size());
    end
    @(posedge clk_i); #1;
    rstn_i = 1'b0;
    #1;
    nchk++;
    if ({data_tx_ready_o, tx_valid_o, tx_sof_o, tx_eof_o, busy_o, done_o, tx_data_o} !== 14'h0) begin
      nerr++;
      $display("FAIL async_reset_outputs: got %h, expected 0",
               {data_tx_ready_o, tx_valid_o, tx_sof_o, tx_eof_o, busy_o, done_o, tx_data_o});
    end
    exp_q.delete();
    wq.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(8'hC0 + 8'(i));
    load_frame(8);
    start(8);
    wait_done(300);
  endtask

  task automatic test_clamp;
    pl.delete();
    for (int i = 0; i < 1514; i++) pl.push_back(8'(i * 7));
    load_frame(1514);
    start(2000);
    wait_done(5000);
  endtask

`ifdef ETH_FCS_EN
  task automatic test_fcs;
    logic [31:0] c;
    logic [31:0] res;
    pl.delete();
    for (int i = 0; i < 60; i++) pl.push_back(8'($urandom_range(0, 255)));
    rx_bytes.delete();
    load_frame(60);
    start(60);
    wait_done(400);
    nchk++;
    if (rx_bytes.size() != 64) begin
      nerr++;
      $display("FAIL fcs_length: got %0d bytes, expected 64", rx_bytes.size());
    end
    c = 32'hFFFFFFFF;
    foreach (rx_bytes[i]) c = m_crc(c, rx_bytes[i]);
    res = 32'hC704DD7B;
    for (int i = 0; i < 32; i++) c[i] = c[i];
    nchk++;
    if ({<<{c}} !== res) begin
      nerr++;
      $display("FAIL fcs_residue: got %h, expected %h", {<<{c}}, res);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_short();
    test_full64();
    test_stall61();
    test_ignored_starts();
    test_reset_mid_pad();
    test_clamp();
`ifdef ETH_FCS_EN
    test_fcs();
`endif
    repeat (5) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
